fifo_flag_ctrl: RTL
===================

Name: fifo_flag_ctrl

Overview:
Control and status stage for the team's synchronous FIFO. It sits directly upstream of the write-pointer and read-pointer up-counters and the storage array. It arbitrates raw write/read requests against the FIFO fill state and issues qualified write/read enables, which are the increment strobes for the pointer counters. It also maintains occupancy and produces the registered full, empty, almost-full, almost-empty and sticky error flags.

Parameters:
ADDR_W, 4, pointer/address width; DEPTH = 2**ADDR_W entries
AFULL_TH, 14, almost_full asserts when count >= AFULL_TH (range 1..DEPTH)
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (range 0..DEPTH-1)

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous, active-high reset
clr  input  1  synchronous flush; same effect as rst on all state
wr_req  input  1  producer requests a write this cycle
rd_req  input  1  consumer requests a read this cycle
wr_en  output  1  write accepted; combinational wr_req & ~full
rd_en  output  1  read accepted; combinational rd_req & ~empty
wr_addr  output  ADDR_W  storage write address (low bits of write pointer)
rd_addr  output  ADDR_W  storage read address (low bits of read pointer)
count  output  ADDR_W+1  occupancy, 0..DEPTH
full  output  1  count == DEPTH, registered
empty  output  1  count == 0, registered
almost_full  output  1  registered, count >= AFULL_TH
almost_empty  output  1  registered, count <= AEMPTY_TH
overflow  output  1  sticky: set on wr_req while full
underflow  output  1  sticky: set on rd_req while empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. The polarity and synchronicity of rst are fixed. rst has priority over clr, and clr has priority over all other activity.
- Reset and clr values: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Pointers:
  - Internal wr_ptr and rd_ptr are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - Each pointer increments by 1 on the rising edge when its enable is high.
  - Pointers wrap naturally from 2**(ADDR_W+1)-1 to 0.
  - wr_addr = wr_ptr[ADDR_W-1:0] and rd_addr = rd_ptr[ADDR_W-1:0]. They change in the cycle after an accepted op.
- Enables are combinational from the registered flags:
  - When full and both requests are high, only the read is accepted.
  - When empty and both requests are high, only the write is accepted (no fall-through).
- Count update, in priority order:
  - wr_en & ~rd_en -> count+1.
  - rd_en & ~wr_en -> count-1.
  - Both or neither -> count unchanged.
  - count never leaves 0..DEPTH.
- Flags: all are computed from next-count and registered, so they are valid in the same cycle as the updated count (one cycle after the triggering edge's request).
- Errors:
  - overflow sets when wr_req & full.
  - underflow sets when rd_req & empty.
  - Both hold until rst or clr. Rejected requests never move pointers or count.
- Invariant: count == wr_ptr - rd_ptr (mod 2**(ADDR_W+1)).
  - full means pointers are equal in the low bits with wrap bits differing.
  - empty means the pointers are fully equal.
- Mid-operation clr: any requests in the same cycle are ignored, and no error flags are set that cycle.

Decomposition:
- Shared package fifo_pkg holds:
  - default ADDR_W;
  - derived localparams DEPTH and CNT_W = ADDR_W+1;
  - a typedef for the pointer (logic [CNT_W-1:0]) and one for occupancy.
- One natural sub-module: two instances of the existing enable-gated up counter serve as wr_ptr and rd_ptr. Each is driven with SIZE=ADDR_W+1, its valid input = the request, and its flag input = full (write side) or empty (read side).
- Occupancy and flag logic stay local.

Test Plan:
- Reset: assert rst 2 cycles with wr_req=1 -> count=0, empty=1, almost_empty=1, full=0, wr_en=0 during reset, overflow=0.
- Fill: 16 consecutive wr_req -> count steps 1..16; almost_full rises after the 14th write; full=1 after the 16th. A 17th wr_req gives wr_en=0, count stays 16, overflow=1 and remains 1.
- Drain: from full, 16 rd_req -> count 16..0; almost_empty rises at count=2; empty=1 after the 16th. A 17th read gives rd_en=0 and underflow=1.
- Simultaneous ops:
  - At count=8, wr_req=rd_req=1 for 5 cycles -> count stays 8, both addrs advance by 5.
  - At full, both high -> only the read is accepted, count=15.
  - At empty, both high -> only the write is accepted, count=1.
- Wrap-around: 40 writes interleaved with 40 reads (occupancy kept at 3) -> addrs wrap past 15 to 0, the wrap bit toggles, count remains 3, full never asserts.
- Flush: at count=10 with overflow=1, pulse clr together with wr_req -> next cycle count=0, empty=1, overflow=0, wr_addr=rd_addr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO control slice.
//   ADDR_W_DEF : default address width of the storage array
//   DEPTH      : number of storage entries for the default width
//   CNT_W      : pointer / occupancy width (one extra wrap bit)
//   ptr_t      : read/write pointer type (MSB is the wrap bit)
//   occ_t      : occupancy type, holds 0..DEPTH
//   occ_step() : next occupancy for a given accepted write/read pair
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int CNT_W      = ADDR_W_DEF + 1;

  typedef logic [CNT_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] occ_t;

  // A simultaneous accepted write and read leaves the occupancy unchanged.
  function automatic int occ_step(input int cur, input logic inc, input logic dec);
    int nxt;
    nxt = cur;
    if (inc && !dec) begin
      nxt = cur + 1;
    end else if (dec && !inc) begin
      nxt = cur - 1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_flag_ctrl_up_cnt.sv
// ---------------------------------------------------------------------------
// fifo_flag_ctrl_up_cnt
// Enable-gated up counter used as a FIFO pointer. A request (valid) is
// accepted only when the blocking flag is low and no reset/flush is active;
// the accepted strobe is exported as en and advances the pointer by one.
// The pointer carries one wrap bit above the address bits; it wraps
// naturally at 2**SIZE.
//   clk   : clock
//   rst   : synchronous active-high reset (pointer -> 0)
//   clr   : synchronous flush (pointer -> 0, requests ignored)
//   valid : raw request
//   flag  : blocking condition (full for writes, empty for reads)
//   en    : accepted request, combinational
//   addr  : pointer value without the wrap bit
// ---------------------------------------------------------------------------
module fifo_flag_ctrl_up_cnt #(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            valid,
  input  logic            flag,
  output logic            en,
  output logic [SIZE-2:0] addr
);

  logic [SIZE-1:0] ptr_r;

  // Reset and flush also gate the strobe so counters and occupancy stay in step.
  assign en   = valid & ~flag & ~rst & ~clr;
  assign addr = ptr_r[SIZE-2:0];

  // Pointer register: clears on reset/flush, otherwise steps on an accepted request.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr_r <= {SIZE{1'b0}};
    end else if (en) begin
      ptr_r <= ptr_r + {{(SIZE-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fifo_flag_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_flag_ctrl
// Control and status stage of the synchronous FIFO. Qualifies raw write and
// read requests against the registered fill flags, drives the two pointer
// counters, tracks occupancy and produces registered status/error flags.
//   clk          : clock
//   rst          : synchronous active-high reset (highest priority)
//   clr          : synchronous flush, same effect as rst
//   wr_req       : producer write request
//   rd_req       : consumer read request
//   wr_en        : accepted write (wr_req & ~full)
//   rd_en        : accepted read  (rd_req & ~empty)
//   wr_addr      : storage write address
//   rd_addr      : storage read address
//   count        : occupancy 0..DEPTH
//   full/empty   : registered occupancy extremes
//   almost_full  : registered, count >= AFULL_TH
//   almost_empty : registered, count <= AEMPTY_TH
//   overflow     : sticky, write requested while full
//   underflow    : sticky, read requested while empty
// ---------------------------------------------------------------------------
module fifo_flag_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW          = ADDR_W + 1;
  localparam int NUM_ENTRIES = 2 ** ADDR_W;

  logic          wr_en_s;
  logic          rd_en_s;
  logic [PW-1:0] count_nxt_s;
  logic          full_nxt_s;
  logic          empty_nxt_s;
  logic          afull_nxt_s;
  logic          aempty_nxt_s;

  logic [PW-1:0] count_r;
  logic          full_r;
  logic          empty_r;
  logic          afull_r;
  logic          aempty_r;
  logic          overflow_r;
  logic          underflow_r;

  // Write pointer: blocked by full, so with both requests at full only the read goes.
  fifo_flag_ctrl_up_cnt #(
    .SIZE (PW)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .valid (wr_req),
    .flag  (full_r),
    .en    (wr_en_s),
    .addr  (wr_addr)
  );

  // Read pointer: blocked by empty, so a write into an empty FIFO never falls through.
  fifo_flag_ctrl_up_cnt #(
    .SIZE (PW)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .valid (rd_req),
    .flag  (empty_r),
    .en    (rd_en_s),
    .addr  (rd_addr)
  );

  // Next occupancy and the flags derived from it, so flags line up with count.
  always_comb begin
    count_nxt_s  = count_r;
    full_nxt_s   = 1'b0;
    empty_nxt_s  = 1'b1;
    afull_nxt_s  = 1'b0;
    aempty_nxt_s = 1'b1;

    count_nxt_s  = PW'(occ_step(int'(count_r), wr_en_s, rd_en_s));
    full_nxt_s   = (count_nxt_s == PW'(NUM_ENTRIES));
    empty_nxt_s  = (count_nxt_s == {PW{1'b0}});
    afull_nxt_s  = (count_nxt_s >= PW'(AFULL_TH));
    aempty_nxt_s = (count_nxt_s <= PW'(AEMPTY_TH));
  end

  // Occupancy, status flags and sticky errors; a flush cycle raises no error.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r     <= {PW{1'b0}};
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      afull_r     <= 1'b0;
      aempty_r    <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r  <= count_nxt_s;
      full_r   <= full_nxt_s;
      empty_r  <= empty_nxt_s;
      afull_r  <= afull_nxt_s;
      aempty_r <= aempty_nxt_s;
      if (wr_req && full_r) begin
        overflow_r <= 1'b1;
      end
      if (rd_req && empty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign wr_en        = wr_en_s;
  assign rd_en        = rd_en_s;
  assign count        = count_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
